// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch constants and state encoding
// Contents: XLEN, RISC-V NOP encoding, fetch FSM state type.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - PC, instruction-memory and decode signals of the fetch unit
// Signals: PC/stall/flush, imem req/addr/gnt/rvalid/rdata, decode valid/instr/pc/ready.
// master = fetch unit, slave = surrounding core/memory/decode.
// Optional (IFETCH_MISALIGN_CHECK_EN): o_instr_misaligned.
interface instr_fetch_if #(
  parameter int XLEN = core_pkg::XLEN
);

  logic            [XLEN-1:0] i_pc;
  logic                       o_stall;
  logic                       i_flush;
  logic                       o_imem_req;
  logic            [XLEN-1:0] o_imem_addr;
  logic                       i_imem_gnt;
  logic                       i_imem_rvalid;
  logic            [XLEN-1:0] i_imem_rdata;
  logic                       o_instr_valid;
  logic            [XLEN-1:0] o_instr;
  logic            [XLEN-1:0] o_instr_pc;
  logic                       i_decode_ready;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic                       o_instr_misaligned;
`endif

  modport master (
    input  i_pc, i_flush, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_decode_ready,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output o_instr_misaligned,
`endif
    output o_stall, o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
  );

  modport slave (
    output i_pc, i_flush, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_decode_ready,
`ifdef IFETCH_MISALIGN_CHECK_EN
    input  o_instr_misaligned,
`endif
    input  o_stall, o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered storage and occupancy count
// Ports: i_clk, i_rst (async, active-high), i_clr (sync empty), i_push/i_wdata,
//        i_pop, o_rdata (head, zero read latency), o_count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = i_pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = i_push & (~full | do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch with credit-limited requests and flush
// Ports: i_clk, i_rst (async, active-high), bus (instr_fetch_if.master):
//   PC in / stall out, flush, imem req/addr/gnt/rvalid/rdata, decode valid/instr/pc/ready.
// Optional macro IFETCH_MISALIGN_CHECK_EN: misaligned PCs produce a flagged NOP entry
//   (o_instr_misaligned) instead of a memory request.
module instr_fetch #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  instr_fetch_if.master bus
);

  import core_pkg::*;

`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam int EW = 2 * XLEN + 1;
`else
  localparam int EW = 2 * XLEN;
`endif

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count, pend_count;
  logic [XLEN-1:0]  pend_addr;
  logic [EW-1:0]    ibuf_wdata, ibuf_rdata;
  logic             rvalid_ok, keep_rsp, credit_ok, req, grant, ibuf_push, ibuf_pop;

  // Responses with nothing outstanding are protocol violations and are dropped.
  assign rvalid_ok = bus.i_imem_rvalid & (outstanding_q != '0);
  // A response is kept only when it belongs to the current (non-flushed) stream.
  assign keep_rsp  = rvalid_ok & (discard_q == '0) & ~bus.i_flush;
  // Buffered plus in-flight words may never exceed the buffer depth.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned, synth_push, trap_q;
  assign misaligned = (bus.i_pc[1:0] != 2'b00);
  // Wait for in-flight words to land so the synthetic entry stays in program order;
  // trap_q keeps the held PC from inserting it again until the trap flush.
  assign synth_push = (state_q == ST_RUN) & ~bus.i_flush & credit_ok & misaligned &
                      ~trap_q & (outstanding_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            trap_q <= 1'b0;
    else if (bus.i_flush) trap_q <= 1'b0;
    else if (synth_push)  trap_q <= 1'b1;
  end
`endif

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    req           = (state_q == ST_RUN) & ~bus.i_flush & credit_ok;
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (misaligned) req = 1'b0;
`endif
    grant = req & bus.i_imem_gnt;

    case ({grant, rvalid_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Everything still in flight at a flush is stale; a response landing in the
    // flush cycle itself is already accounted for here.
    if (bus.i_flush)
      discard_d = outstanding_q - CNT_W'(rvalid_ok);
    else if (rvalid_ok && discard_q != '0)
      discard_d = discard_q - CNT_W'(1);

    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (bus.i_flush && discard_d != '0) state_d = ST_FLUSH;
      ST_FLUSH: state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Addresses of granted requests, matched in order with their responses.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_pend_q (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (bus.i_flush),
    .i_push  (grant),
    .i_wdata (bus.i_pc),
    .i_pop   (keep_rsp),
    .o_rdata (pend_addr),
    .o_count (pend_count)
  );

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign ibuf_push  = keep_rsp | synth_push;
  assign ibuf_wdata = synth_push ? {1'b1, bus.i_pc, XLEN'(NOP_INSTR)}
                                 : {1'b0, pend_addr, bus.i_imem_rdata};
  assign bus.o_instr_misaligned = ibuf_rdata[2*XLEN];
`else
  assign ibuf_push  = keep_rsp;
  assign ibuf_wdata = {pend_addr, bus.i_imem_rdata};
`endif

  assign ibuf_pop = bus.o_instr_valid & bus.i_decode_ready;

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_ibuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (bus.i_flush),
    .i_push  (ibuf_push),
    .i_wdata (ibuf_wdata),
    .i_pop   (ibuf_pop),
    .o_rdata (ibuf_rdata),
    .o_count (fifo_count)
  );

  assign bus.o_imem_req    = req;
  assign bus.o_imem_addr   = bus.i_pc;
  assign bus.o_stall       = ~grant;
  assign bus.o_instr_valid = (fifo_count != '0);
  assign bus.o_instr       = ibuf_rdata[XLEN-1:0];
  assign bus.o_instr_pc    = ibuf_rdata[2*XLEN-1:XLEN];

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.i_imem_rvalid && outstanding_q == '0));
  a_pend_tracks_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
    (discard_q == '0) |-> (pend_count == outstanding_q));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic clk, rst;
  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(.XLEN(32), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_t;

  mem_t        mq[$];
  int          errors, checks, cyc, epoch, pops, pops_since_flush;
  int          gnt_mode, ready_mode, lat_lo, lat_hi, first_v;
  logic [31:0] pc_m, exp_pc, flush_tgt, first_pc;
  logic        flush_req, just_flushed;
  logic        last_req, last_stall, last_valid;
  logic [31:0] last_addr, last_ipc;
  int          last_cyc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit has_stale();
    foreach (mq[i]) if (mq[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    bus.i_pc = pc_m;
    case (gnt_mode)
      0:       bus.i_imem_gnt = 1'b0;
      1:       bus.i_imem_gnt = 1'b1;
      default: bus.i_imem_gnt = ($urandom_range(0, 9) < 7);
    endcase
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = word_of(mq[0].addr);
    end else begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = $urandom;
    end
    case (ready_mode)
      0:       bus.i_decode_ready = 1'b0;
      1:       bus.i_decode_ready = 1'b1;
      default: bus.i_decode_ready = ($urandom_range(0, 9) < 7);
    endcase
    bus.i_flush = flush_req;
  endtask

  // One clock: drive, sample at negedge, update the reference model, advance.
  task automatic tick();
    logic req, stl, pop, fl;
    mem_t e;
    drive_inputs();
    @(negedge clk);
    req = bus.o_imem_req;
    stl = bus.o_stall;
    fl  = bus.i_flush;
    pop = bus.o_instr_valid && bus.i_decode_ready;
    last_cyc = cyc; last_req = req; last_stall = stl; last_addr = bus.o_imem_addr;
    last_valid = bus.o_instr_valid; last_ipc = bus.o_instr_pc;

    check("stall", 32'(stl), 32'(!(req && bus.i_imem_gnt)));
    if (req) check("addr", bus.o_imem_addr, pc_m);
    if (just_flushed || has_stale()) check("drop", 32'(bus.o_instr_valid), 32'd0);
    just_flushed = 1'b0;
    if (pop) begin
      check("ipc", bus.o_instr_pc, exp_pc);
      check("instr", bus.o_instr, word_of(exp_pc));
      if (pops_since_flush == 0) first_pc = bus.o_instr_pc;
      pops_since_flush++;
      pops++;
      exp_pc += 32'd4;
    end
    if (bus.i_imem_rvalid) void'(mq.pop_front());
    if (req && bus.i_imem_gnt) begin
      e.addr  = pc_m;
      e.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
      e.epoch = epoch;
      mq.push_back(e);
      check("credit", 32'(mq.size() <= DEPTH), 32'd1);
    end
    if (fl) begin
      epoch++;
      exp_pc = flush_tgt;
      pc_m = flush_tgt;
      flush_req = 1'b0;
      just_flushed = 1'b1;
      pops_since_flush = 0;
    end else if (!stl) begin
      pc_m += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_valid"}, 32'(bus.o_instr_valid), 32'd0);
    check({tag, "_req"},   32'(bus.o_imem_req), 32'd0);
    check({tag, "_stall"}, 32'(bus.o_stall), 32'd1);
    check({tag, "_instr"}, bus.o_instr, 32'd0);
    check({tag, "_ipc"},   bus.o_instr_pc, 32'd0);
  endtask

  initial begin
    int n;
    errors = 0; checks = 0; cyc = 0; epoch = 0; pops = 0; pops_since_flush = 0;
    flush_req = 1'b0; just_flushed = 1'b0; flush_tgt = '0; first_pc = '1;
    pc_m = 32'h0; exp_pc = 32'h0;
    gnt_mode = 1; ready_mode = 1; lat_lo = 1; lat_hi = 1;
    rst = 1'b1;
    bus.i_pc = '0; bus.i_flush = 1'b0; bus.i_imem_gnt = 1'b0;
    bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0; bus.i_decode_ready = 1'b0;
    #3;
    check_reset_outputs("rst");

    // Startup: gnt=1, 1-cycle latency, ready=1, PC 0.
    @(posedge clk); #1; rst = 1'b0;
    first_v = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check("idle_req", 32'(last_req), 32'd0);
      if (last_valid && first_v < 0) first_v = last_cyc;
    end
    check("first_valid_cycle", first_v, 32'd3);
    check("startup_pops", 32'(pops >= 6), 32'd1);

    // Grant withheld at PC 0x100: request and address held, PC stalled.
    gnt_mode = 0;
    for (int i = 0; i < 6; i++) tick();
    flush_req = 1'b1; flush_tgt = 32'h100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", 32'(last_req), 32'd1);
      check("hold_addr", last_addr, 32'h100);
      check("hold_stall", 32'(last_stall), 32'd1);
    end

    // Decode stalled: buffer fills with 0x0/0x4, requests stop.
    gnt_mode = 1; ready_mode = 0;
    flush_req = 1'b1; flush_tgt = 32'h0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    check("full_req", 32'(last_req), 32'd0);
    check("full_stall", 32'(last_stall), 32'd1);
    check("full_valid", 32'(last_valid), 32'd1);
    check("full_head", last_ipc, 32'h0);
    ready_mode = 1;
    for (int i = 0; i < 6; i++) tick();

    // Flush with two requests in flight; their late responses must be dropped.
    lat_lo = 4; lat_hi = 4;
    n = 0;
    while (mq.size() < 2 && n < 20) begin tick(); n++; end
    check("flush_out2", mq.size(), 32'd2);
    flush_req = 1'b1; flush_tgt = 32'h200;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("flush_first_pc", first_pc, 32'h200);

    // Asynchronous reset with two in flight; a stray response during reset.
    n = 0;
    while (mq.size() < 2 && n < 20) begin tick(); n++; end
    check("rst_out2", mq.size(), 32'd2);
    #2; rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    bus.i_imem_rvalid = 1'b1; bus.i_imem_rdata = 32'hDEAD_BEEF;
    mq.delete();
    @(posedge clk); @(posedge clk); #1;
    bus.i_imem_rvalid = 1'b0;
    pc_m = 32'h40; exp_pc = 32'h40; epoch++; just_flushed = 1'b0; pops_since_flush = 0;
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(last_valid), 32'd0);

    // Randomized traffic against the in-order stream model.
    gnt_mode = 2; ready_mode = 2; lat_lo = 1; lat_hi = 3;
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        flush_req = 1'b1;
        flush_tgt = 32'($urandom_range(0, 1023)) << 2;
      end
      tick();
    end
    check("progress", 32'(pops > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
